// File: rtl/wall_scheduler.sv
// Wall layout scheduler: LFSR-driven candidate generation, range/overlap screening,
// shadow bank committed on a frame boundary. Optional overlap test: WALL_OVERLAP_CHECK_EN.
module wall_scheduler #(
    parameter logic [9:0] MAX_X = 10'd575,
    parameter logic [9:0] MAX_Y = 10'd415
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       Start,
    input  logic [9:0] SW,
    output logic       Busy,
    output logic       Done,
    output logic [9:0] X1,
    output logic [9:0] Y1,
    output logic [9:0] X2,
    output logic [9:0] Y2,
    output logic [9:0] X3,
    output logic [9:0] Y3,
    output logic [9:0] X4,
    output logic [9:0] Y4
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] GEN     = 3'd1;
    localparam logic [2:0] CHECK   = 3'd2;
    localparam logic [2:0] WAIT_VS = 3'd3;
    localparam logic [2:0] COMMIT  = 3'd4;

    logic [2:0]  state;
    logic [15:0] lfsr;
    logic [1:0]  idx;
    logic        frame_q;
    logic [9:0]  sh_x [4];
    logic [9:0]  sh_y [4];

    logic [9:0]  cx, cy;
    logic        in_range;
    logic        frame_rise;
    logic        reject_overlap;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    assign cx         = lfsr[9:0];
    assign cy         = lfsr[15:6];
    assign in_range   = (cx <= MAX_X) && (cy <= MAX_Y);
    // A sampled rising edge is only acted on in the following cycle, so one seen during CHECK is lost.
    assign frame_rise = frame_clk & ~frame_q;

`ifdef WALL_OVERLAP_CHECK_EN
    localparam logic [9:0] SPAN      = 10'd64;
    localparam logic [3:0] RETRY_MAX = 4'd15;

    logic [3:0] retries;
    logic       overlap;

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    always_comb begin
        overlap = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k < int'(idx) &&
                abs_diff(cx, sh_x[k]) < SPAN && abs_diff(cy, sh_y[k]) < SPAN)
                overlap = 1'b1;
        end
    end

    assign reject_overlap = overlap && (retries < RETRY_MAX);
`else
    assign reject_overlap = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            lfsr    <= 16'hB400;
            idx     <= 2'd0;
            frame_q <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                sh_x[i] <= 10'd0;
                sh_y[i] <= 10'd0;
            end
            X1 <= 10'd10;  Y1 <= 10'd20;
            X2 <= 10'd400; Y2 <= 10'd200;
            X3 <= 10'd320; Y3 <= 10'd240;
            X4 <= 10'd560; Y4 <= 10'd400;
`ifdef WALL_OVERLAP_CHECK_EN
            retries <= 4'd0;
`endif
        end else begin
            frame_q <= frame_clk;
            Done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        lfsr  <= {6'b101101, SW};
                        idx   <= 2'd0;
                        Busy  <= 1'b1;
                        state <= GEN;
`ifdef WALL_OVERLAP_CHECK_EN
                        retries <= 4'd0;
`endif
                    end
                end
                GEN: begin
                    lfsr  <= lfsr_next(lfsr);
                    state <= CHECK;
                end
                CHECK: begin
                    if (!in_range) begin
                        state <= GEN;
                    end else if (reject_overlap) begin
`ifdef WALL_OVERLAP_CHECK_EN
                        retries <= retries + 4'd1;
`endif
                        state <= GEN;
                    end else begin
                        sh_x[idx] <= cx;
                        sh_y[idx] <= cy;
`ifdef WALL_OVERLAP_CHECK_EN
                        retries <= 4'd0;
`endif
                        if (idx == 2'd3) begin
                            state <= WAIT_VS;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= GEN;
                        end
                    end
                end
                WAIT_VS: begin
                    if (frame_rise)
                        state <= COMMIT;
                end
                COMMIT: begin
                    X1 <= sh_x[0]; Y1 <= sh_y[0];
                    X2 <= sh_x[1]; Y2 <= sh_y[1];
                    X3 <= sh_x[2]; Y3 <= sh_y[2];
                    X4 <= sh_x[3]; Y4 <= sh_y[3];
                    Done  <= 1'b1;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wall_scheduler.sv
// Bench for wall_scheduler: directed sequence with randomized seeds against a layout model.
module tb_wall_scheduler;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       Start;
    logic [9:0] SW;
    logic       Busy, Done;
    logic [9:0] X1, Y1, X2, Y2, X3, Y3, X4, Y4;

    int checks   = 0;
    int failures = 0;

    localparam logic [79:0] RESET_LAY = {10'd10, 10'd20, 10'd400, 10'd200,
                                         10'd320, 10'd240, 10'd560, 10'd400};

    logic [79:0] cur_lay;
    logic [79:0] lay0, lay_a, lay_b;

    wall_scheduler dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Start(Start), .SW(SW),
        .Busy(Busy), .Done(Done),
        .X1(X1), .Y1(Y1), .X2(X2), .Y2(Y2), .X3(X3), .Y3(Y3), .X4(X4), .Y4(Y4)
    );

    always #5 Clk = ~Clk;

    function automatic logic [79:0] outs();
        return {X1, Y1, X2, Y2, X3, Y3, X4, Y4};
    endfunction

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Walks the seed's pseudo-random sequence wall by wall; n counts candidates drawn.
    task automatic model(input logic [9:0] sw, output logic [79:0] lay,
                         output int n, output bit forced);
        logic [15:0] l;
        int xs[4], ys[4];
        int x, y, tries;
        l = {6'b101101, sw};
        n = 0;
        forced = 0;
        for (int w = 0; w < 4; w++) begin
            tries = 0;
            for (int g = 0; g < 100000; g++) begin
                l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
                n++;
                x = int'(l[9:0]);
                y = int'(l[15:6]);
                if (x > 575 || y > 415) continue;
`ifdef WALL_OVERLAP_CHECK_EN
                begin
                    bit hit = 0;
                    for (int k = 0; k < w; k++)
                        if (absd(x, xs[k]) < 64 && absd(y, ys[k]) < 64) hit = 1;
                    if (hit && tries < 15) begin
                        tries++;
                        continue;
                    end
                    if (hit) forced = 1;
                end
`endif
                xs[w] = x;
                ys[w] = y;
                break;
            end
        end
        lay = {10'(xs[0]), 10'(ys[0]), 10'(xs[1]), 10'(ys[1]),
               10'(xs[2]), 10'(ys[2]), 10'(xs[3]), 10'(ys[3])};
    endtask

    // mode 0: normal; 1: frame edge coincides with last accept (must be missed); 2: Start during WAIT_VS
    task automatic do_run(input logic [9:0] sw, input int mode, output logic [79:0] got);
        logic [79:0] exp;
        int n, dones;
        bit forced, ok;
        int xs[4], ys[4];
        model(sw, exp, n, forced);
        SW = sw;
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        check("busy_after_start", 80'(Busy), 80'd1);
        if (mode == 1) begin
            tick(2 * n - 1);
            frame_clk = 1'b1;
            dones = 0;
            for (int i = 0; i < 4; i++) begin
                tick(1);
                if (Done) dones++;
            end
            check("missed_edge_no_done", 80'(dones), 80'd0);
            check("missed_edge_outs_hold", outs(), cur_lay);
            frame_clk = 1'b0;
            tick(1);
        end else begin
            tick(2 * n + 1);
            check("wait_busy", 80'(Busy), 80'd1);
            check("wait_outs_hold", outs(), cur_lay);
            if (mode == 2) begin
                Start = 1'b1;
                tick(1);
                Start = 1'b0;
            end
        end
        frame_clk = 1'b1;
        tick(1);
        check("done_not_early", 80'(Done), 80'd0);
        tick(1);
        check("done_pulse", 80'(Done), 80'd1);
        check("layout", outs(), exp);
        check("busy_clear", 80'(Busy), 80'd0);
        dones = 1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (Done) dones++;
        end
        check("single_done", 80'(dones), 80'd1);
        frame_clk = 1'b0;
        if (mode == 2) check("no_restart", 80'(Busy), 80'd0);
        got = outs();
        cur_lay = exp;
        ok = 1;
        for (int w = 0; w < 4; w++) begin
            xs[w] = int'(got[79 - 20 * w -: 10]);
            ys[w] = int'(got[69 - 20 * w -: 10]);
            if (xs[w] > 575 || ys[w] > 415) ok = 0;
        end
        check("range", 80'(ok), 80'd1);
`ifdef WALL_OVERLAP_CHECK_EN
        if (!forced) begin
            ok = 1;
            for (int a = 0; a < 4; a++)
                for (int b = a + 1; b < 4; b++)
                    if (absd(xs[a], xs[b]) < 64 && absd(ys[a], ys[b]) < 64) ok = 0;
            check("separation", 80'(ok), 80'd1);
        end
`endif
    endtask

    initial begin
        logic [79:0] exp;
        int n, dones;
        bit forced;
        Reset = 1'b0;
        Start = 1'b0;
        frame_clk = 1'b0;
        SW = 10'd0;
        cur_lay = RESET_LAY;
        tick(2);
        Reset = 1'b1;
        tick(1);
        check("reset_outs", outs(), RESET_LAY);
        check("reset_busy", 80'(Busy), 80'd0);
        check("reset_done", 80'(Done), 80'd0);

        do_run(10'h000, 0, lay0);
        do_run(10'h000, 0, lay_a);
        check("determinism", lay_a, lay0);
        do_run(10'h3FF, 0, lay_b);
        check("seed_differs", 80'(lay_b !== lay0), 80'd1);

        // Reset in the middle of generation.
        SW = 10'h155;
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        tick(1);
        Reset = 1'b0;
        #1;
        check("midgen_reset_outs", outs(), RESET_LAY);
        check("midgen_reset_busy", 80'(Busy), 80'd0);
        check("midgen_reset_done", 80'(Done), 80'd0);
        tick(1);
        Reset = 1'b1;
        cur_lay = RESET_LAY;
        tick(1);

        do_run(10'h2A7, 1, lay_a);
        do_run(10'h0C3, 2, lay_a);

        // Reset while waiting for the frame edge.
        model(10'h011, exp, n, forced);
        SW = 10'h011;
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        tick(2 * n + 2);
        Reset = 1'b0;
        #1;
        check("waitvs_reset_outs", outs(), RESET_LAY);
        check("waitvs_reset_busy", 80'(Busy), 80'd0);
        tick(1);
        Reset = 1'b1;
        cur_lay = RESET_LAY;
        frame_clk = 1'b1;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (Done) dones++;
        end
        frame_clk = 1'b0;
        check("waitvs_reset_no_done", 80'(dones), 80'd0);
        check("waitvs_reset_outs_hold", outs(), RESET_LAY);
        tick(1);
        do_run(10'h011, 0, lay_a);

        for (int r = 0; r < 6; r++)
            do_run(10'($urandom_range(0, 1023)), 0, lay_a);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wall_scheduler.md
# wall_scheduler

Generates and commits a new set of four wall positions (X1..X4, Y1..Y4) for the playfield whenever a level starts. It sits between game control and the wall renderer. A 16-bit LFSR seeded from the switches produces candidate positions, which are range-checked and optionally overlap-checked. Accepted positions are held in a shadow bank and swapped into the outputs only on a frame boundary, so the display never tears.

## Interface
- MAX_X, 10'd575, largest legal wall X (640 − 64 − 1)
- MAX_Y, 10'd415, largest legal wall Y (480 − 64 − 1)
- SPAN, 10'd64, exclusion box edge used for overlap test
- RETRY_MAX, 4'd15, overlap rejections tolerated per wall before overlap is ignored
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-low reset
- frame_clk  in  1  frame strobe from VGA controller; rising edge = frame boundary
- Start  in  1  one-cycle request to generate a new layout
- SW  in  10  seed bits
- Busy  out  1  high from accepted Start until commit cycle inclusive
- Done  out  1  one-cycle pulse in the cycle outputs update
- X1, X2, X3, X4, Y1, Y2, Y3, Y4  out  10 each  committed wall top-left coordinates

## Operation
- LFSR: 16 bits, shifts left. New bit 0 = l[15]^l[13]^l[12]^l[10]. Seed = {6'b101101, SW}, which is never zero.
- Candidate: X = l[9:0], Y = l[15:6], taken from the current LFSR value.
- Range check: accept only if X ≤ MAX_X and Y ≤ MAX_Y. Out-of-range candidates are always rejected; the retry count does not apply to them.
- Overlap check: a candidate overlaps entry k (k < idx) if |X − Xk| < SPAN and |Y − Yk| < SPAN. Differences are unsigned 10-bit absolute values.
- States:
  - IDLE: on Start, load seed, idx=0, retries=0, Busy=1, go to GEN. Start is ignored in every other state.
  - GEN: step the LFSR once, go to CHECK.
  - CHECK:
    - Rejected, out of range: go to GEN.
    - Rejected, overlap with retries < RETRY_MAX: retries++, go to GEN.
    - Otherwise: shadow[idx] ← (X, Y), retries=0. If idx = 3, go to WAIT_VS; else idx++, go to GEN.
  - WAIT_VS: wait for a frame_clk rising edge, detected from a registered copy of frame_clk. Go to COMMIT.
  - COMMIT: copy shadow 0..3 to X1/Y1..X4/Y4, Done=1, Busy=0 next cycle, go to IDLE.
- Reset values:
  - X1=10, Y1=20, X2=400, Y2=200, X3=320, Y3=240, X4=560, Y4=400.
  - Shadow bank cleared to 0, LFSR = 16'hB400, state IDLE, Busy=0, Done=0, frame_clk edge register 0.
- Reset asserted mid-generation aborts immediately. Outputs return to reset values and no partial layout is ever committed.
- Outputs change only in COMMIT.

## Timing
- Start sampled on Clk rising edge; Busy rises the following cycle.
- Each candidate costs 2 cycles (GEN + CHECK). The best-case Start-to-WAIT_VS time is 8 cycles.
- A frame_clk rising edge is recognised one cycle after it is sampled.
- If the edge occurs in the same cycle CHECK accepts wall 3, it is missed and the block waits for the next frame.
- Done and the new outputs appear together, one cycle after WAIT_VS sees the edge.
- A Start arriving in the COMMIT cycle is ignored. A Start in the cycle after COMMIT is accepted.

## Configuration
- WALL_OVERLAP_CHECK_EN defined: overlap rejection and the retry counter are implemented as described.
- Not defined: CHECK accepts any in-range candidate and the retry counter is absent. Cycle timing is otherwise identical.

## Test plan
- Reset behaviour: assert Reset low mid-GEN -> X1..Y4 read 10,20,400,200,320,240,560,400; Busy=0; Done=0.
- Basic commit: SW=10'h000, pulse Start, frame_clk held low -> Busy=1, outputs unchanged. Raise frame_clk -> Done pulses once 2 cycles later and all X ≤ 575, all Y ≤ 415.
- Determinism: same SW seed run twice -> identical committed layouts. SW=10'h3FF -> a different layout.
- Overlap check: with WALL_OVERLAP_CHECK_EN defined, all committed pairs satisfy |ΔX| ≥ 64 or |ΔY| ≥ 64, unless the checker logs a retry count of 15.
- Start while busy: pulse Start during WAIT_VS -> no restart, single Done.
- Mid-operation reset: assert Reset during WAIT_VS, then release -> no Done and outputs at reset values. A new Start completes normally.
